fetch_unit: RTL and testbench

Instruction-fetch and program-counter stage that sits directly upstream of the instruction decoder/control unit. It owns the PC register, issues instruction-memory reads over a req/ack handshake, and latches the returned word. It presents the opcode/funct3/funct7 fields to the control unit for one execute window, then selects the next PC from the control unit's Branch/PcUpdate outputs and the datapath target.

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC stage: owns the PC, fetches over a req/ack handshake, and holds each instruction for one execute window.
// Optional macro MISALIGN_TRAP_EN: a jump/branch target with bit 1 set halts the stage and raises the sticky misaligned flag.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        pc_update,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        instr_valid,
    output logic        misaligned
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]  state;
    logic        redirect;
    logic        trap;
    logic [31:0] next_pc;

    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_EXEC);
    assign pc_plus4    = pc + 32'd4;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Targets are forced word-aligned; clearing bit 0 also covers the JALR rule.
    always_comb begin
        redirect = branch | pc_update;
        next_pc  = redirect ? (target & 32'hFFFF_FFFC) : pc_plus4;
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = redirect & target[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misaligned <= 1'b0;
        end else if (state == S_EXEC && !stall && trap) begin
            misaligned <= 1'b1;
        end
    end
`else
    assign trap       = 1'b0;
    assign misaligned = 1'b0;
`endif

    // HALT is only entered through a trap, so it is unreachable when the trap is disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= NOP;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        if (trap) begin
                            state <= S_HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected fetch addresses are queued when the PC decision is driven and popped on each accepted fetch.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        pc_update = 1'b0;
    logic [31:0] target = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        instr_valid;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] pc_model;
    logic [31:0] last_instr;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .branch(branch),
        .pc_update(pc_update),
        .target(target),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .instr(instr),
        .opcode(opcode),
        .funct3(funct3),
        .funct7(funct7),
        .instr_valid(instr_valid),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Called with the DUT in FETCH; returns with the DUT in EXEC holding word.
    task automatic do_fetch(input logic [31:0] word, input int wait_cycles);
        logic [31:0] exp_addr;
        imem_ack = 1'b0;
        exp_addr = 32'h0;
        checks++;
        if (exp_addr_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL fetch_queue: got no pending address, required one");
        end else begin
            exp_addr = exp_addr_q.pop_front();
        end
        for (int i = 0; i < wait_cycles; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                errors++;
                $display("[TB] FAIL fetch_wait: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, exp_addr);
            end
            checks++;
            if (instr !== last_instr) begin
                errors++;
                $display("[TB] FAIL instr_hold: instr=%h, required %h", instr, last_instr);
            end
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_addr || pc !== exp_addr) begin
            errors++;
            $display("[TB] FAIL fetch_addr: req=%b addr=%h pc=%h, required req=1 addr=%h", imem_req, imem_addr, pc, exp_addr);
        end
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL exec_entry: valid=%b req=%b, required valid=1 req=0", instr_valid, imem_req);
        end
        checks++;
        if (instr !== word || opcode !== word[6:0] || funct3 !== word[14:12] || funct7 !== word[31:25]) begin
            errors++;
            $display("[TB] FAIL instr_fields: instr=%h op=%h f3=%h f7=%h, required instr=%h", instr, opcode, funct3, funct7, word);
        end
        last_instr = word;
    endtask

    // Called with the DUT in EXEC; holds stall for stall_cycles (with noise on ignored inputs), then decides the next PC.
    task automatic do_exec(input logic br, input logic pu, input logic [31:0] tgt, input int stall_cycles);
        logic [31:0] exp_pc;
        for (int i = 0; i < stall_cycles; i++) begin
            stall      = 1'b1;
            branch     = 1'b1;
            target     = 32'h1234_5678;
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_0BAD;
            step();
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_state: valid=%b req=%b, required valid=1 req=0", instr_valid, imem_req);
            end
            checks++;
            if (pc !== pc_model || instr !== last_instr) begin
                errors++;
                $display("[TB] FAIL stall_hold: pc=%h instr=%h, required pc=%h instr=%h", pc, instr, pc_model, last_instr);
            end
        end
        stall      = 1'b0;
        branch     = br;
        pc_update  = pu;
        target     = tgt;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0BAD;
        exp_pc = (br | pu) ? (tgt & 32'hFFFF_FFFC) : pc_model + 32'd4;
        exp_addr_q.push_back(exp_pc);
        pc_model = exp_pc;
        step();
        branch    = 1'b0;
        pc_update = 1'b0;
        imem_ack  = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || instr !== last_instr) begin
            errors++;
            $display("[TB] FAIL exec_exit: valid=%b req=%b instr=%h, required valid=0 req=1 instr=%h", instr_valid, imem_req, instr, last_instr);
        end
    endtask

    task automatic restart_model;
        pc_model   = RESET_PC;
        last_instr = NOP;
        exp_addr_q.delete();
        exp_addr_q.push_back(RESET_PC);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        step();
        step();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misaligned !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: req=%b valid=%b mis=%b, required 0 0 0", imem_req, instr_valid, misaligned);
        end
        checks++;
        if (pc !== RESET_PC || pc_plus4 !== RESET_PC + 32'd4 || instr !== NOP) begin
            errors++;
            $display("[TB] FAIL reset_regs: pc=%h pc4=%h instr=%h, required %h %h %h", pc, pc_plus4, instr, RESET_PC, RESET_PC + 32'd4, NOP);
        end
        reset = 1'b1;
        restart_model();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_cycle: req=%b, required 0", imem_req);
        end
        step();
    endtask

    task automatic test_basic_fetch;
        do_fetch(NOP, 0);
        do_exec(1'b0, 1'b0, 32'h0, 0);
    endtask

    task automatic test_delayed_ack;
        do_fetch(32'h00A0_0093, 3);
        do_exec(1'b1, 1'b0, 32'h0040_0100, 0);
    endtask

    task automatic test_redirect;
        do_fetch(32'hFE20_8AE3, 0);
        do_exec(1'b0, 1'b0, 32'h0, 0);
        do_fetch(32'h0080_00EF, 0);
        do_exec(1'b0, 1'b1, 32'h0040_0021, 0);
        do_fetch(32'h4000_D033, 1);
        do_exec(1'b1, 1'b1, 32'h0040_0203, 0);
    endtask

    task automatic test_stall;
        do_fetch(32'h0010_0073, 0);
        do_exec(1'b0, 1'b0, 32'h0, 2);
    endtask

    task automatic test_wrap;
        do_fetch(NOP, 0);
        do_exec(1'b1, 1'b0, 32'hFFFF_FFFC, 0);
        do_fetch(32'h0000_0033, 0);
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL wrap_link: pc=%h pc4=%h, required fffffffc 00000000", pc, pc_plus4);
        end
        do_exec(1'b0, 1'b0, 32'h0, 0);
        do_fetch(NOP, 0);
        do_exec(1'b0, 1'b0, 32'h0, 0);
    endtask

    task automatic test_reset_mid_fetch;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_req: req=%b, required 1", imem_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== RESET_PC || instr !== NOP || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: req=%b pc=%h instr=%h valid=%b, required 0 %h %h 0", imem_req, pc, instr, instr_valid, RESET_PC, NOP);
        end
        step();
        reset = 1'b1;
        restart_model();
        step();
        do_fetch(32'h0020_8093, 0);
        do_exec(1'b0, 1'b0, 32'h0, 0);
    endtask

    task automatic test_misalign;
        do_fetch(32'h0000_8067, 0);
`ifdef MISALIGN_TRAP_EN
        pc_update = 1'b1;
        target    = 32'h0040_0102;
        step();
        pc_update = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            checks++;
            if (misaligned !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== pc_model) begin
                errors++;
                $display("[TB] FAIL halt_state: mis=%b req=%b valid=%b pc=%h, required 1 0 0 %h", misaligned, imem_req, instr_valid, pc, pc_model);
            end
            step();
        end
        imem_ack = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (misaligned !== 1'b0 || pc !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL halt_reset: mis=%b pc=%h, required 0 %h", misaligned, pc, RESET_PC);
        end
        step();
        reset = 1'b1;
        restart_model();
        step();
        do_fetch(NOP, 0);
        do_exec(1'b0, 1'b0, 32'h0, 0);
`else
        do_exec(1'b0, 1'b1, 32'h0040_0102, 0);
        do_fetch(NOP, 0);
        checks++;
        if (misaligned !== 1'b0 || pc !== 32'h0040_0100) begin
            errors++;
            $display("[TB] FAIL misalign_clear: mis=%b pc=%h, required 0 00400100", misaligned, pc);
        end
        do_exec(1'b0, 1'b0, 32'h0, 0);
`endif
    endtask

    initial begin
        $display("[TB] fetch_unit bench start");
        test_reset();
        test_basic_fetch();
        test_delayed_ack();
        test_redirect();
        test_stall();
        test_wrap();
        test_reset_mid_fetch();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
